// File: rtl/sms_pkg.sv
// Shared types for the state move sequencer: FSM states, operation kind, snap index width.
package sms_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_REQ     = 4'd1,
        ST_GATE    = 4'd2,
        ST_SAVE    = 4'd3,
        ST_RESTORE = 4'd4,
        ST_STEP    = 4'd5,
        ST_STEP1   = 4'd6,
        ST_SETTLE  = 4'd7,
        ST_WAIT    = 4'd8,
        ST_RESUME  = 4'd9
    } state_t;

    typedef enum logic {
        OP_DUMP = 1'b0,
        OP_LOAD = 1'b1
    } op_t;

    function automatic int sms_idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sms_cycle_counter.sv
// DUT cycle counter with registered breakpoint compare (compare only with SMS_BREAKPOINT_EN).
// Latency: count updates the edge after i_inc; bp_hit one edge after the match. No backpressure.
module sms_cycle_counter #(
    parameter int CYC_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_idle,
    input  logic [CYC_W-1:0] i_breakpoint,
    output logic [CYC_W-1:0] o_count,
    output logic             o_bp_hit
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_inc) begin
            o_count <= o_count + CYC_W'(1);
        end
    end

`ifdef SMS_BREAKPOINT_EN
    // all-ones breakpoint means disabled
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_bp_hit <= 1'b0;
        end else begin
            o_bp_hit <= i_idle && (o_count == i_breakpoint) && !(&i_breakpoint);
        end
    end
`else
    logic w_unused_bp;
    assign w_unused_bp = i_idle ^ (^i_breakpoint);
    assign o_bp_hit    = 1'b0;
`endif

endmodule

// File: rtl/state_move_sequencer.sv
// Task-interruption capture/restore sequencer for a clock-gated DUT; auto-dump needs SMS_BREAKPOINT_EN.
// Outputs registered one edge after the state; holds in REQ until ti_gnt, requests while busy are dropped.
module state_move_sequencer
    import sms_pkg::*;
#(
    parameter int  NUM_SNAPSHOTS = 4,
    parameter int  GAP_CYCLES    = 2,
    parameter int  SETTLE_CYCLES = 30,
    parameter int  CYC_W         = 32,
    localparam int IDX_W         = sms_idx_w(NUM_SNAPSHOTS)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             dump_req,
    input  logic             load_req,
    input  logic [CYC_W-1:0] breakpoint,
    input  logic             ti_gnt,
    output logic             ti_req,
    output logic             clk_en,
    output logic             clk_step,
    output logic             clk_step_1,
    output logic             save,
    output logic             restore,
    output logic [IDX_W-1:0] snap_idx,
    output logic             pr_done,
    output logic             busy,
    output logic             req_drop,
    output logic [CYC_W-1:0] cycle_count
);

    state_t           r_state;
    state_t           r_nxt;
    op_t              r_op;
    logic [31:0]      r_cnt;
    logic [IDX_W-1:0] r_k;
    logic             r_drop;
    logic             w_bp_hit;
    logic             w_idle;
    logic             w_inc;

    assign w_idle = (r_state == ST_IDLE);
    assign w_inc  = clk_en | clk_step | clk_step_1;

    sms_cycle_counter #(
        .CYC_W (CYC_W)
    ) u_cnt (
        .i_clk        (ap_clk),
        .i_rst_n      (ap_rst_n),
        .i_inc        (w_inc),
        .i_idle       (w_idle),
        .i_breakpoint (breakpoint),
        .o_count      (cycle_count),
        .o_bp_hit     (w_bp_hit)
    );

    // Outputs decode the state of the previous cycle, giving the one-edge lag the host expects.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ti_req     <= 1'b0;
            clk_en     <= 1'b1;
            clk_step   <= 1'b0;
            clk_step_1 <= 1'b0;
            save       <= 1'b0;
            restore    <= 1'b0;
            snap_idx   <= '0;
            pr_done    <= 1'b0;
            busy       <= 1'b0;
            r_drop     <= 1'b0;
            req_drop   <= 1'b0;
        end else begin
            ti_req     <= (r_state != ST_IDLE) && (r_state != ST_RESUME);
            clk_en     <= (r_state == ST_IDLE) || (r_state == ST_REQ) || (r_state == ST_RESUME);
            clk_step   <= (r_state == ST_STEP);
            clk_step_1 <= (r_state == ST_STEP1);
            save       <= (r_state == ST_SAVE);
            restore    <= (r_state == ST_RESTORE);
            pr_done    <= (r_state == ST_RESUME);
            busy       <= (r_state != ST_IDLE);
            r_drop     <= (r_state != ST_IDLE) && (dump_req || load_req);
            req_drop   <= r_drop;
            if (r_state == ST_SAVE) begin
                snap_idx <= r_k;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
            r_nxt   <= ST_IDLE;
            r_op    <= OP_DUMP;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (load_req) begin
                        r_op    <= OP_LOAD;
                        r_state <= ST_REQ;
                    end else if (dump_req || w_bp_hit) begin
                        r_op    <= OP_DUMP;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ti_gnt) begin
                        r_cnt   <= '0;
                        r_state <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (r_cnt == 32'(GAP_CYCLES - 1)) begin
                        r_k     <= '0;
                        r_state <= (r_op == OP_DUMP) ? ST_SAVE : ST_RESTORE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_SAVE: begin
                    if (r_k == IDX_W'(NUM_SNAPSHOTS - 1)) begin
                        r_state <= ST_RESUME;
                    end else begin
                        r_cnt   <= '0;
                        r_nxt   <= ST_STEP;
                        r_state <= ST_WAIT;
                    end
                end
                ST_STEP: begin
                    r_k     <= r_k + IDX_W'(1);
                    r_cnt   <= '0;
                    r_nxt   <= ST_SAVE;
                    r_state <= ST_WAIT;
                end
                ST_RESTORE: begin
                    r_cnt   <= '0;
                    r_nxt   <= ST_STEP1;
                    r_state <= ST_WAIT;
                end
                ST_STEP1: begin
                    r_cnt   <= '0;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == 32'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_RESUME;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 32'(GAP_CYCLES - 1)) begin
                        r_state <= r_nxt;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_RESUME: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_move_sequencer.sv
// Scoreboard bench: expected output events queued at stimulus time, matched against observed edges/strobes.
module tb_state_move_sequencer;

    localparam int N  = 4;
    localparam int G  = 2;
    localparam int S  = 30;
    localparam int W  = 32;
    localparam int IW = $clog2(N + 1);

    // event kinds, in the order the monitor reports them within one cycle
    localparam int EV_TIREQ_UP = 0;
    localparam int EV_TIREQ_DN = 1;
    localparam int EV_CLKEN_DN = 2;
    localparam int EV_CLKEN_UP = 3;
    localparam int EV_SAVE     = 4;
    localparam int EV_STEP     = 5;
    localparam int EV_STEP1    = 6;
    localparam int EV_RESTORE  = 7;
    localparam int EV_DONE     = 8;
    localparam int EV_DROP     = 9;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          dump_req = 1'b0;
    logic          load_req = 1'b0;
    logic          ti_gnt   = 1'b1;
    logic [W-1:0]  breakpoint = '1;
    logic          ti_req, clk_en, clk_step, clk_step_1, save, restore, pr_done, busy, req_drop;
    logic [IW-1:0] snap_idx;
    logic [W-1:0]  cycle_count;

    state_move_sequencer #(
        .NUM_SNAPSHOTS (N),
        .GAP_CYCLES    (G),
        .SETTLE_CYCLES (S),
        .CYC_W         (W)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .dump_req    (dump_req),
        .load_req    (load_req),
        .breakpoint  (breakpoint),
        .ti_gnt      (ti_gnt),
        .ti_req      (ti_req),
        .clk_en      (clk_en),
        .clk_step    (clk_step),
        .clk_step_1  (clk_step_1),
        .save        (save),
        .restore     (restore),
        .snap_idx    (snap_idx),
        .pr_done     (pr_done),
        .busy        (busy),
        .req_drop    (req_drop),
        .cycle_count (cycle_count)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int kind;
        int cyc;
        int dat;
    } ev_t;

    ev_t          exp_q[$];
    int           total  = 0;
    int           bad    = 0;
    int           cyc    = 0;
    bit           mon_en = 1'b0;
    logic         p_tireq = 1'b0;
    logic         p_clken = 1'b1;
    logic [W-1:0] c0 = '0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic void push_ev(input int kind, input int c, input int d);
        ev_t e;
        int  i;
        e.kind = kind;
        e.cyc  = c;
        e.dat  = d;
        i = exp_q.size();
        while (i > 0 && (exp_q[i-1].cyc > c || (exp_q[i-1].cyc == c && exp_q[i-1].kind > kind)))
            i--;
        exp_q.insert(i, e);
    endfunction

    task automatic got(input int kind, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("ev%0d_kind", e.kind), kind, e.kind);
            chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
            chk($sformatf("ev%0d_data", e.kind), d, e.dat);
        end
    endtask

    // clk_en rising reports how far cycle_count moved while the DUT was gated
    always @(negedge ap_clk) begin
        if (mon_en) begin
            if (ti_req && !p_tireq)   got(EV_TIREQ_UP, 0);
            if (!ti_req && p_tireq)   got(EV_TIREQ_DN, 0);
            if (!clk_en && p_clken) begin
                c0 = cycle_count;
                got(EV_CLKEN_DN, 0);
            end
            if (clk_en && !p_clken)   got(EV_CLKEN_UP, int'(cycle_count - c0));
            if (save)                 got(EV_SAVE, int'(snap_idx));
            if (clk_step)             got(EV_STEP, 0);
            if (clk_step_1)           got(EV_STEP1, 0);
            if (restore)              got(EV_RESTORE, 0);
            if (pr_done)              got(EV_DONE, 0);
            if (req_drop)             got(EV_DROP, 0);
        end
        p_tireq = ti_req;
        p_clken = clk_en;
    end

    task automatic push_dump(input int t, input int d);
        int e;
        push_ev(EV_TIREQ_UP, t + 1, 0);
        push_ev(EV_CLKEN_DN, t + 2 + d, 0);
        for (int k = 0; k < N; k++) begin
            push_ev(EV_SAVE, t + 2 + G + k * (2 * G + 2) + d, k);
            if (k < N - 1) push_ev(EV_STEP, t + 3 + 2 * G + k * (2 * G + 2) + d, 0);
        end
        e = t + 3 + G + (N - 1) * (2 * G + 2) + d;
        push_ev(EV_TIREQ_DN, e, 0);
        push_ev(EV_CLKEN_UP, e, N - 1);
        push_ev(EV_DONE, e, 0);
    endtask

    task automatic push_load(input int t);
        int e;
        push_ev(EV_TIREQ_UP, t + 1, 0);
        push_ev(EV_CLKEN_DN, t + 2, 0);
        push_ev(EV_RESTORE, t + 2 + G, 0);
        push_ev(EV_STEP1, t + 3 + 2 * G, 0);
        e = t + 4 + 2 * G + S;
        push_ev(EV_TIREQ_DN, e, 0);
        push_ev(EV_CLKEN_UP, e, 1);
        push_ev(EV_DONE, e, 0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic drive_req(input logic d, input logic l, output int t0);
        @(posedge ap_clk);
        #1;
        dump_req = d;
        load_req = l;
        t0 = cyc + 1;
        @(posedge ap_clk);
        #1;
        dump_req = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(posedge ap_clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (8) @(posedge ap_clk);
    endtask

    initial begin
        int t;
        int r;

        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_clk_en", clk_en, 1);
        chk("rst_ti_req", ti_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_save", save, 0);
        chk("rst_pr_done", pr_done, 0);
        chk("rst_req_drop", req_drop, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_snap_idx", snap_idx, 0);
        ap_rst_n = 1'b1;
        mon_en   = 1'b1;

        // breakpoint all-ones: free-running count, no auto-dump
        repeat (130) @(posedge ap_clk);
        #1;
        chk("idle_count", cycle_count, 130);
        chk("ones_busy", busy, 0);

        // breakpoint=100 from a fresh reset: match after edge r+100, registered hit, REQ at r+102
        @(posedge ap_clk);
        #1;
        ap_rst_n   = 1'b0;
        breakpoint = 100;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        r = cyc;
`ifdef SMS_BREAKPOINT_EN
        push_dump(r + 102, 0);
        drain(200);
`else
        repeat (200) @(posedge ap_clk);
`endif
        repeat (60) @(posedge ap_clk);
        #1;
        chk("bp_after_busy", busy, 0);
        breakpoint = '1;

        // plain dump
        drive_req(1'b1, 1'b0, t);
        push_dump(t, 0);
        drain(100);
        #1;
        chk("snap_idx_hold", snap_idx, N - 1);

        // plain load
        drive_req(1'b0, 1'b1, t);
        push_load(t);
        drain(100);

        // grant withheld for 10 cycles
        ti_gnt = 1'b0;
        drive_req(1'b1, 1'b0, t);
        push_dump(t, 10);
        wait_cyc(t + 5);
        chk("nogrant_ti_req", ti_req, 1);
        chk("nogrant_clk_en", clk_en, 1);
        wait_cyc(t + 10);
        ti_gnt = 1'b1;
        drain(100);

        // simultaneous requests (load wins) then a dump while busy
        drive_req(1'b1, 1'b1, t);
        push_load(t);
        push_ev(EV_DROP, t + 6, 0);
        wait_cyc(t + 4);
        dump_req = 1'b1;
        wait_cyc(t + 5);
        dump_req = 1'b0;
        drain(100);

        // reset sampled at T12 of a dump
        drive_req(1'b1, 1'b0, t);
        push_ev(EV_TIREQ_UP, t + 1, 0);
        push_ev(EV_CLKEN_DN, t + 2, 0);
        push_ev(EV_SAVE, t + 4, 0);
        push_ev(EV_STEP, t + 7, 0);
        push_ev(EV_SAVE, t + 10, 1);
        wait_cyc(t + 11);
        ap_rst_n = 1'b0;
        wait_cyc(t + 12);
        mon_en = 1'b0;
        chk("abort_clk_en", clk_en, 1);
        chk("abort_ti_req", ti_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cycle_count", cycle_count, 0);
        chk("abort_pr_done", pr_done, 0);
        ap_rst_n = 1'b1;
        wait_cyc(t + 13);
        mon_en = 1'b1;
        chk("abort_queue", exp_q.size(), 0);
        repeat (40) @(posedge ap_clk);
        #1;
        chk("abort_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/state_move_sequencer.md
# state_move_sequencer

Synthesizable, parametrised sequencer for task-interruption state capture and restore. It issues the ti_req / clk_en / clk_step / save / restore / pr_done control sequence to a clock-gated DUT wrapper, replacing hand-written testbench procedures. It sits between the debug/host control logic and the DUT's clock-gating and state-access ports. Compared with a fixed procedure, it adds:
- configurable snapshot count and gap lengths;
- a real ti_gnt handshake;
- a DUT cycle counter with breakpoint auto-dump;
- busy/drop status.

## Interface
Parameters:
- NUM_SNAPSHOTS, 4: save pulses per dump, ≥1; one clk_step between consecutive saves.
- GAP_CYCLES, 2: idle cycles around every save/restore/step pulse, ≥1.
- SETTLE_CYCLES, 30: cycles held gated after a restore step.
- CYC_W, 32: width of cycle counter and breakpoint.

Ports:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  synchronous, active-low reset.
- dump_req  in  1  one-cycle request: capture sequence.
- load_req  in  1  one-cycle request: restore sequence.
- breakpoint  in  CYC_W  DUT cycle at which to auto-dump; all-ones disables.
- ti_gnt  in  1  task-interruption grant from DUT.
- ti_req  out  1  task-interruption request.
- clk_en  out  1  DUT clock enable.
- clk_step  out  1  single DUT step during dump.
- clk_step_1  out  1  single DUT step after restore.
- save  out  1  one-cycle snapshot strobe.
- restore  out  1  one-cycle restore strobe.
- snap_idx  out  $clog2(NUM_SNAPSHOTS+1)  index of current/last save.
- pr_done  out  1  one-cycle resume strobe.
- busy  out  1  sequence in progress.
- req_drop  out  1  one-cycle: request arrived while busy.
- cycle_count  out  CYC_W  DUT cycles advanced since reset.

## Operation
- All outputs are registered.
- Reset values:
  - clk_en=1.
  - All other outputs 0, including cycle_count and snap_idx.
- FSM states: IDLE, REQ, GATE, SAVE, RESTORE, STEP, STEP1, SETTLE, WAIT, RESUME.
  - WAIT counts GAP_CYCLES, then enters the state held in a next-state register.
- IDLE:
  - load_req → REQ(load).
  - Otherwise dump_req or breakpoint hit → REQ(dump).
  - Load wins if asserted simultaneously.
- REQ: ti_req=1, held until ti_gnt sampled 1, then GATE.
- GATE: clk_en=0 for GAP_CYCLES, then SAVE (dump) or RESTORE (load).
- Dump:
  - SAVE: save=1 one cycle, snap_idx=k.
  - If k<NUM_SNAPSHOTS-1: WAIT → STEP (clk_step=1 one cycle) → WAIT → SAVE k+1.
  - After the last save → RESUME.
- Load: RESTORE (restore=1 one cycle) → WAIT → STEP1 (clk_step_1=1 one cycle) → SETTLE (SETTLE_CYCLES) → RESUME.
- RESUME (one cycle): ti_req=0, clk_en=1, pr_done=1 → IDLE.
- busy=1 in every state except IDLE.
- dump_req/load_req while busy are not queued; req_drop pulses the next cycle.
- cycle_count:
  - Increments each cycle where clk_en|clk_step|clk_step_1 is 1.
  - Wraps modulo 2^CYC_W.
- Breakpoint hit: IDLE && cycle_count==breakpoint && breakpoint!=all-ones.
  - Fires once, because the counter moves past the value while gated.
- Breakpoint coincident with dump_req produces a single dump.
- Reset mid-sequence aborts immediately and restores reset values; clk_en returns to 1 on the next cycle.

## Timing
Request sampled at edge T0. With ti_gnt held 1, GAP_CYCLES=G, NUM_SNAPSHOTS=N:
- ti_req=1 from T1.
- clk_en=0 from T2.
- First save at T2+G.
- Save k at T2+G+k(2G+2).
- Resume strobe (pr_done, clk_en=1, ti_req=0) at T2+G+(N-1)(2G+2)+1.

Load:
- restore at T2+G.
- clk_step_1 at T3+2G.
- pr_done at T4+2G+SETTLE_CYCLES.

ti_gnt low delays every later event 1:1, with ti_req held.

## Configuration
- SMS_BREAKPOINT_EN:
  - Defined: breakpoint compare and auto-dump are present.
  - Undefined: breakpoint port is ignored, the compare logic is removed, and only dump_req/load_req start sequences.
  - cycle_count exists in both cases.

## Structure
- sms_pkg holds:
  - state enum;
  - op enum (OP_DUMP, OP_LOAD);
  - function computing snap_idx width.
- Sub-module sms_cycle_counter: counter plus breakpoint compare (compare under SMS_BREAKPOINT_EN). Output is a registered bp_hit.

## Test plan
- Defaults, ti_gnt=1, dump_req at T0:
  - ti_req T1, clk_en low T2–T22.
  - save at T4/10/16/22 with snap_idx 0–3.
  - clk_step at T7/13/19.
  - pr_done T23.
  - cycle_count +3 during gating.
- Defaults, load_req at T0: restore T4, clk_step_1 T7, pr_done T38, clk_en low T2–T37.
- ti_gnt held 0 for 10 cycles after REQ: ti_req stays high, clk_en stays 1; all later events shift by 10.
- dump_req and load_req same cycle, then dump_req again at T5: load sequence runs; req_drop pulses at T6; no second sequence.
- breakpoint=100 (SMS_BREAKPOINT_EN): dump starts when cycle_count=100; exactly one dump. With breakpoint=all-ones, or the macro undefined, no dump occurs.
- ap_rst_n=0 at T12 of a dump: next cycle clk_en=1, ti_req=0, busy=0, cycle_count=0; no pr_done pulse.
